// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types for the load/store unit controller.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_LAT  = 3'd2,
        WR      = 3'd3,
        RMW_RD  = 3'd4,
        RMW_MRG = 3'd5,
        RMW_WR  = 3'd6,
        DONE    = 3'd7
    } state_e;

    // Reserved size or an access that is not naturally aligned.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            SZ_RSV:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_fmt
//  Description : Combinational load-data extraction and store lane merge.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_fmt
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] word_in,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = word_in[{lane, 3'b000} +: 8];
        w_half  = lane[1] ? word_in[31:16] : word_in[15:0];
        ld_data = word_in;
        merged  = st_data;
        case (size)
            SZ_B: begin
                ld_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
                merged  = word_in;
                merged[{lane, 3'b000} +: 8] = st_data[7:0];
            end
            SZ_H: begin
                ld_data = {{16{~is_unsigned & w_half[15]}}, w_half};
                merged  = word_in;
                if (lane[1]) begin
                    merged[31:16] = st_data[15:0];
                end else begin
                    merged[15:0] = st_data[15:0];
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Single-outstanding load/store controller with read-modify-
//                write for sub-word stores on a word-wide synchronous memory.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [31:0]           mem_rdata
);

    state_e                state_q, state_d;
    logic                  unsigned_q, unsigned_d;
    logic                  err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           w_ld_data;
    logic [31:0]           w_merged;

    lsu_fmt u_fmt (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .lane        (addr_q[1:0]),
        .word_in     (mem_rdata),
        .st_data     (wdata_q),
        .ld_data     (w_ld_data),
        .merged      (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            unsigned_q <= unsigned_d;
            err_q      <= err_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        unsigned_d = unsigned_q;
        err_d      = err_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    unsigned_d = req_unsigned;
                    size_d     = req_size;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    if (is_bad_access(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (!req_we) begin
                        state_d = RD;
                    end else if (req_size == SZ_W) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD:      state_d = RD_LAT;
            RD_LAT: begin
                rdata_d = w_ld_data;
                state_d = DONE;
            end
            WR:      state_d = DONE;
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                wdata_d = w_merged;
                state_d = RMW_WR;
            end
            RMW_WR:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes depend only on the state register so they never glitch on inputs.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_err   = (state_q == DONE) & err_q;
    assign resp_rdata = (state_q == DONE) ? rdata_q : 32'd0;
    assign mem_re     = (state_q == RD) | (state_q == RMW_RD);
    assign mem_we     = (state_q == WR) | (state_q == RMW_WR);
    assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of core request and memory address.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  block accepts request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  formatted load data (0 for stores/errors).
REQ-013 resp_err  output  1  misaligned or reserved-size request; valid with resp_valid.
REQ-014 mem_addr  output  ADDR_WIDTH  word-aligned address (bits [1:0]=0).
REQ-015 mem_wdata  output  32  word write data.
REQ-016 mem_we / mem_re  output  1 each  write / read strobes, never both high.
REQ-017 mem_rdata  input  32  read data, valid the cycle after mem_re (synchronous memory).

Function
REQ-018 FSM states SHALL be IDLE, RD, RD_LAT, WR, RMW_RD, RMW_MRG, RMW_WR, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; all request fields latched then.
REQ-020 Accept at cycle T: word store IDLE->WR(T+1)->DONE(T+2).
REQ-021 Load: IDLE->RD(T+1, mem_re=1)->RD_LAT(T+2, capture mem_rdata)->DONE(T+3).
REQ-022 Byte/half store: IDLE->RMW_RD(T+1, mem_re=1)->RMW_MRG(T+2, capture and merge lane)->RMW_WR(T+3, mem_we=1)->DONE(T+4).
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: IDLE->DONE(T+1), resp_err=1, no memory strobe.
REQ-024 DONE SHALL assert resp_valid for exactly one cycle, then go to IDLE; next accept no earlier than DONE+1.
REQ-025 mem_we/mem_re SHALL be decoded from current state only; mem_addr = {latched addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-026 Little-endian lanes: byte lane = addr[1:0], half lane = addr[1]; merge preserves all other bytes.
REQ-027 Load extract: byte/half shifted to bit 0, bits above extended per req_unsigned; word passed unchanged.
REQ-028 req_valid while not in IDLE SHALL be ignored (no latch, no side effect).

Reset
REQ-029 rst SHALL asynchronously force IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-030 rst in any state, including RMW_WR, SHALL abort with no memory write and no resp_valid.

Structure
REQ-031 Package lsu_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W, SZ_RSV) and the FSM state enum.
REQ-032 Sub-module lsu_fmt (combinational load extract + store lane merge) SHALL be instantiated once; FSM and registers stay in lsu_ctrl.

Verification
REQ-033 Word store addr 0x10, data 0xDEADBEEF -> mem_we at T+1, mem_addr 0x10, mem_wdata 0xDEADBEEF; resp_valid at T+2, err 0.
REQ-034 Byte load addr 0x13, memory word 0x80FF0102 -> signed resp_rdata 0xFFFFFF80, unsigned 0x00000080, resp_valid at T+3.
REQ-035 Half store addr 0x22, data 0x0000ABCD, memory word 0x11223344 -> mem_re T+1, mem_we T+3 with wdata 0xABCD3344, resp_valid T+4.
REQ-036 Word load addr 0x06 and size 11 at addr 0x00 -> resp_valid at T+1, err=1, mem_re/mem_we never asserted.
REQ-037 rst pulsed during RMW_MRG of byte store -> mem_we never asserts, memory unchanged, req_ready=1 immediately.
REQ-038 req_valid held high continuously with back-to-back word loads -> accepts exactly one request per DONE+1 cycle, none dropped or duplicated.
